bool_sweep_checker: RTL and testbench
=====================================

# bool_sweep_checker

Self-running exhaustive checker for an N-input, 1-output combinational function. It steps a registered stimulus bus through all 2^N_IN input combinations, in binary or Gray order, and holds each vector for HOLD cycles to let the DUT settle. It then compares the DUT output against a parameterised truth table and reports mismatch count, first failing vector and pass/fail. It sits beside the boolean blocks as a synthesizable in-system replacement for hand-toggled stimulus.

## Interface
Parameters:
- N_IN, default 3: number of DUT inputs, range 1..8.
- TRUTH, default 8'hE8: expected output table, width 2^N_IN. Bit k is the expected output for input vector k. The default is 3-input majority.
- HOLD, default 2: cycles each vector is held before sampling, at least 1.
- GRAY, default 0: sweep order. 0 = binary 0,1,2,…; 1 = reflected Gray order g(i) = i ^ (i>>1).

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: sweep request, sampled only in IDLE or DONE.
- dut_i, in, 1: DUT output under test.
- stim_o, out, N_IN: registered DUT input vector.
- busy, out, 1: high while a sweep is running.
- done, out, 1: high from sweep completion until the next accepted start or reset.
- pass, out, 1: valid while done is high; 1 when err_cnt == 0.
- err_cnt, out, N_IN+1: number of mismatches. Saturation cannot occur because the maximum is 2^N_IN.
- first_err_vld, out, 1: at least one mismatch seen in the current sweep.
- first_err_idx, out, N_IN: stim_o value, not sweep position, of the first mismatch.

## Operation
- FSM states are IDLE, RUN and DONE.
- On reset: state goes to IDLE. stim_o, busy, done, pass, err_cnt, first_err_vld, first_err_idx and the internal index and hold counters all go to 0.
- IDLE with start=1 → RUN. Initialisation on that edge:
  - index and hold counter clear.
  - err_cnt, first_err_vld and first_err_idx clear.
  - stim_o = order(0), which is 0 in both orders.
  - busy = 1.
- In RUN, the hold counter counts 0..HOLD-1. In the cycle where hold == HOLD-1:
  - dut_i is compared with TRUTH[stim_o].
  - On mismatch: err_cnt increments. If first_err_vld = 0, first_err_idx is set to stim_o and first_err_vld is set to 1.
  - If index < 2^N_IN-1: index increments, stim_o = order(index+1) and hold clears.
  - Otherwise: state → DONE, busy = 0, done = 1, pass = (final err_cnt == 0), and stim_o returns to 0.
- DONE with start=1 → RUN, with the same initialisation as from IDLE. done and pass drop on that edge.
- start is ignored while in RUN.
- All comparison bookkeeping uses the updated err_cnt value, so a mismatch on the last vector is reflected in pass.

## Timing
- start is sampled at edge E, and busy/stim_o = order(0) are visible after E.
- Vector k is driven from E + k·HOLD through E + (k+1)·HOLD − 1 cycles.
- dut_i is sampled at edge E + (k+1)·HOLD. DUT combinational delay must be less than HOLD cycles.
- done rises at edge E + 2^N_IN·HOLD, on the same edge busy falls. There is no overlap cycle and no gap cycle.
- Reset during RUN: all outputs return to reset values on the next edge. No done or pass is produced, and a later start begins a fresh sweep.
- start and rst asserted in the same cycle: rst wins.
- HOLD = 1: a new vector every cycle, and dut_i is sampled in the same cycle the vector is driven.
- N_IN = 1: two vectors; err_cnt is 2 bits.

## Structure
- Package bool_sweep_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the function bin2gray(i) = i ^ (i>>1);
  - the localparam computing 2^N_IN from N_IN.
- Sub-module sweep_index_gen holds the index counter, the hold counter and the order mapping (binary or Gray, selected by GRAY). Its outputs are the current vector, a sample strike and a last-vector flag. The checker FSM and error bookkeeping stay in the top block.

## Test plan
- N_IN=3, TRUTH=8'hE8, HOLD=2, GRAY=0, correct majority DUT model; start pulse → stim_o walks 0..7, each value held 2 cycles. done rises 16 cycles after busy rises, with pass=1, err_cnt=0 and first_err_vld=0.
- Same setup, DUT stuck at 0 → err_cnt=4, first_err_vld=1, first_err_idx=3, pass=0.
- GRAY=1, DUT stuck at 0 → stim_o sequence 0,1,3,2,6,7,5,4; err_cnt=4, first_err_idx=3.
- GRAY=1, DUT stuck at 1 → first_err_idx=0, err_cnt=4.
- HOLD=1, correct DUT → 8 consecutive vectors, and done 8 cycles after start.
- rst asserted at the 5th RUN cycle → all outputs 0 on the next edge and done never rises.
- Extra start pulses during RUN → no effect.
- Start issued in DONE → fresh sweep, with err_cnt cleared on the accept edge.

Source files
------------

// File: rtl/bool_sweep_pkg.sv
// Shared types and helpers for the exhaustive boolean sweep checker.
// Holds the checker state encoding, the Gray mapping and the vector-count helper.
package bool_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned MAX_N_IN = 8;

   function automatic logic [MAX_N_IN-1:0] bin2gray(input logic [MAX_N_IN-1:0] i);
      return i ^ (i >> 1);
   endfunction

   // Number of input combinations for an n-input function (2^n).
   function automatic int unsigned num_vec(input int unsigned n);
      return 32'd1 << n;
   endfunction

endpackage

// File: rtl/bool_sweep_checker_index_gen.sv
// Sweep position, hold counter and binary/Gray order mapping for the sweep checker.
// The vector is registered here so the DUT input never glitches.
module sweep_index_gen
   import bool_sweep_pkg::*;
#(
   parameter int N_IN = 3,
   parameter int HOLD = 2,
   parameter int GRAY = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            init_i,
   input  logic            run_i,
   output logic [N_IN-1:0] vec_o,
   output logic            sample_o,
   output logic            last_o
);

   localparam int unsigned NUM_VEC = num_vec(N_IN);
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   logic [N_IN-1:0] idx_q, idx_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [N_IN-1:0] nxt_idx_s;
   logic [N_IN-1:0] gray_s;
   logic [N_IN-1:0] nxt_vec_s;

   assign sample_o = run_i && (hold_q == HW'(HOLD - 1));
   assign last_o   = (idx_q == N_IN'(NUM_VEC - 1));
   assign vec_o    = vec_q;

   // Order mapping of the next sweep position onto the stimulus value.
   always_comb begin
      nxt_idx_s = idx_q + N_IN'(1);
      gray_s    = N_IN'(bin2gray(MAX_N_IN'(nxt_idx_s)));
      if (GRAY != 0) begin
         nxt_vec_s = gray_s;
      end else begin
         nxt_vec_s = nxt_idx_s;
      end
   end

   // Position/hold advance; the final sample parks everything back at zero.
   always_comb begin
      idx_d  = idx_q;
      vec_d  = vec_q;
      hold_d = hold_q;
      if (init_i) begin
         idx_d  = '0;
         vec_d  = '0;
         hold_d = '0;
      end else if (run_i) begin
         if (sample_o) begin
            if (last_o) begin
               idx_d  = '0;
               vec_d  = '0;
               hold_d = '0;
            end else begin
               idx_d  = nxt_idx_s;
               vec_d  = nxt_vec_s;
               hold_d = '0;
            end
         end else begin
            hold_d = hold_q + HW'(1);
         end
      end else begin
         idx_d  = idx_q;
      end
   end

   // Counter and vector registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         vec_q  <= '0;
         hold_q <= '0;
      end else begin
         idx_q  <= idx_d;
         vec_q  <= vec_d;
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/bool_sweep_checker.sv
// Self-running exhaustive checker for an N-input, 1-output combinational block.
// Sweeps every input vector, compares against TRUTH and reports errors and pass/fail.
module bool_sweep_checker
   import bool_sweep_pkg::*;
#(
   parameter int                   N_IN  = 3,
   parameter logic [2**N_IN-1:0]   TRUTH = 8'hE8,
   parameter int                   HOLD  = 2,
   parameter int                   GRAY  = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_i,
   output logic [N_IN-1:0] stim_o,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            first_err_vld,
   output logic [N_IN-1:0] first_err_idx
);

   state_e          state_q, state_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_q, err_d;
   logic            fev_q, fev_d;
   logic [N_IN-1:0] fei_q, fei_d;

   logic            init_s;
   logic            run_s;
   logic            sample_s;
   logic            last_s;
   logic [N_IN-1:0] vec_s;
   logic            mismatch_s;
   logic [N_IN:0]   err_nxt_s;

   sweep_index_gen #(
      .N_IN (N_IN),
      .HOLD (HOLD),
      .GRAY (GRAY)
   ) u_index_gen (
      .clk      (clk),
      .rst      (rst),
      .init_i   (init_s),
      .run_i    (run_s),
      .vec_o    (vec_s),
      .sample_o (sample_s),
      .last_o   (last_s)
   );

   assign stim_o        = vec_s;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_q;
   assign first_err_vld = fev_q;
   assign first_err_idx = fei_q;

   assign run_s      = (state_q == ST_RUN);
   assign mismatch_s = (dut_i != TRUTH[vec_s]);

   // Checker FSM and error bookkeeping; pass uses the post-increment count.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      err_d     = err_q;
      fev_d     = fev_q;
      fei_d     = fei_q;
      init_s    = 1'b0;
      err_nxt_s = err_q + ((N_IN+1)'(mismatch_s));
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               init_s  = 1'b1;
               state_d = ST_RUN;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               err_d   = '0;
               fev_d   = 1'b0;
               fei_d   = '0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (sample_s) begin
               err_d = err_nxt_s;
               if (mismatch_s && !fev_q) begin
                  fev_d = 1'b1;
                  fei_d = vec_s;
               end else begin
                  fev_d = fev_q;
               end
               if (last_s) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_nxt_s == '0);
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   // State and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fei_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fei_q   <= fei_d;
      end
   end

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Scoreboard bench: three checker instances (binary/HOLD2, Gray/HOLD2, binary/HOLD1)
// driving a majority / stuck-at-0 / stuck-at-1 DUT model.
module tb_bool_sweep_checker;

   typedef struct {
      int pass;
      int err;
      int fev;
      int fei;
      int lat;
   } res_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [2:0] busy_v;
   logic [2:0] done_v;
   logic [2:0] pass_v;
   logic [2:0] fev_v;
   logic [2:0] dut_in_v;
   logic [2:0] stim_a [3];
   logic [3:0] err_a  [3];
   logic [2:0] fei_a  [3];
   int         mode_a [3];
   int         start_cyc [3];
   int         vq [3][$];
   res_t       rq [3][$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int H  = (g == 2) ? 1 : 2;
      localparam int GR = (g == 1) ? 1 : 0;
      logic done_prev = 1'b0;
      res_t r;

      bool_sweep_checker #(
         .N_IN  (3),
         .TRUTH (8'hE8),
         .HOLD  (H),
         .GRAY  (GR)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .start         (start_v[g]),
         .dut_i         (dut_in_v[g]),
         .stim_o        (stim_a[g]),
         .busy          (busy_v[g]),
         .done          (done_v[g]),
         .pass          (pass_v[g]),
         .err_cnt       (err_a[g]),
         .first_err_vld (fev_v[g]),
         .first_err_idx (fei_a[g])
      );

      // mode 0: majority, 1: stuck at 0, 2: stuck at 1
      assign dut_in_v[g] = (mode_a[g] == 1) ? 1'b0 :
                           (mode_a[g] == 2) ? 1'b1 :
                           ((stim_a[g][0] & stim_a[g][1]) | (stim_a[g][0] & stim_a[g][2]) |
                            (stim_a[g][1] & stim_a[g][2]));

      always @(negedge clk) begin
         if (busy_v[g]) begin
            if (vq[g].size() == 0) chk($sformatf("stim_extra_u%0d", g), int'(stim_a[g]), -1);
            else chk($sformatf("stim_seq_u%0d", g), int'(stim_a[g]), vq[g].pop_front());
         end
         if (done_v[g] && !done_prev) begin
            if (rq[g].size() == 0) begin
               chk($sformatf("spurious_done_u%0d", g), 1, 0);
            end else begin
               r = rq[g].pop_front();
               chk($sformatf("pass_u%0d", g), int'(pass_v[g]), r.pass);
               chk($sformatf("err_cnt_u%0d", g), int'(err_a[g]), r.err);
               chk($sformatf("first_vld_u%0d", g), int'(fev_v[g]), r.fev);
               chk($sformatf("first_idx_u%0d", g), int'(fei_a[g]), r.fei);
               chk($sformatf("busy_at_done_u%0d", g), int'(busy_v[g]), 0);
               chk($sformatf("latency_u%0d", g), cyc - start_cyc[g], r.lat);
            end
         end
         done_prev = done_v[g];
      end
   end

   task automatic check_zero(input int g, input string tag);
      chk({tag, "_stim"}, int'(stim_a[g]), 0);
      chk({tag, "_busy"}, int'(busy_v[g]), 0);
      chk({tag, "_done"}, int'(done_v[g]), 0);
      chk({tag, "_pass"}, int'(pass_v[g]), 0);
      chk({tag, "_err"},  int'(err_a[g]), 0);
      chk({tag, "_fev"},  int'(fev_v[g]), 0);
      chk({tag, "_fei"},  int'(fei_a[g]), 0);
   endtask

   task automatic sweep(input int g, input int mode, input int hold, input int gray,
                        input int exp_err, input int exp_fei, input int pokes);
      int   seq_bin  [8];
      int   seq_gray [8];
      int   n;
      res_t r;
      seq_bin  = '{0, 1, 2, 3, 4, 5, 6, 7};
      seq_gray = '{0, 1, 3, 2, 6, 7, 5, 4};
      mode_a[g] = mode;
      for (int k = 0; k < 8; k++) begin
         for (int h = 0; h < hold; h++) vq[g].push_back(gray != 0 ? seq_gray[k] : seq_bin[k]);
      end
      r.pass = (exp_err == 0) ? 1 : 0;
      r.err  = exp_err;
      r.fev  = (exp_err != 0) ? 1 : 0;
      r.fei  = exp_fei;
      r.lat  = 8 * hold;
      rq[g].push_back(r);
      @(negedge clk);
      start_v[g] = 1'b1;
      @(posedge clk);
      #1;
      start_v[g] = 1'b0;
      start_cyc[g] = cyc;
      chk($sformatf("accept_busy_u%0d", g), int'(busy_v[g]), 1);
      chk($sformatf("accept_done_u%0d", g), int'(done_v[g]), 0);
      chk($sformatf("accept_err_u%0d", g), int'(err_a[g]), 0);
      chk($sformatf("accept_fev_u%0d", g), int'(fev_v[g]), 0);
      chk($sformatf("accept_stim_u%0d", g), int'(stim_a[g]), 0);
      for (int p = 0; p < pokes; p++) begin
         repeat (2) @(negedge clk);
         start_v[g] = 1'b1;
         @(negedge clk);
         start_v[g] = 1'b0;
      end
      n = 0;
      while (!done_v[g] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done_v[g]) chk($sformatf("timeout_u%0d", g), int'(done_v[g]), 1);
      @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      start_v = 3'b000;
      for (int g = 0; g < 3; g++) begin
         mode_a[g]    = 0;
         start_cyc[g] = 0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) check_zero(g, $sformatf("reset_u%0d", g));
      rst = 1'b0;

      sweep(0, 0, 2, 0, 0, 0, 0);   // majority, binary: pass
      sweep(0, 1, 2, 0, 4, 3, 3);   // stuck-0 with extra starts during RUN
      sweep(0, 0, 2, 0, 0, 0, 0);   // restart from DONE after failing sweep
      sweep(1, 1, 2, 1, 4, 3, 0);   // Gray, stuck-0
      sweep(1, 2, 2, 1, 4, 0, 0);   // Gray, stuck-1
      sweep(2, 0, 1, 0, 0, 0, 0);   // HOLD=1 majority

      // Reset landing on the 5th RUN cycle, with start asserted alongside it.
      mode_a[0] = 1;
      vq[0].push_back(0);
      vq[0].push_back(0);
      vq[0].push_back(1);
      vq[0].push_back(1);
      vq[0].push_back(2);
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (5) @(negedge clk);
      rst        = 1'b1;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      start_v[0] = 1'b0;
      check_zero(0, "midrun_rst_u0");
      repeat (20) @(negedge clk);
      chk("no_done_after_rst", int'(done_v[0]), 0);
      sweep(0, 0, 2, 0, 0, 0, 0);   // fresh sweep after reset

      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("vq_drained_u%0d", g), vq[g].size(), 0);
         chk($sformatf("rq_drained_u%0d", g), rq[g].size(), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
